// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg: shared FSM state type and command encodings for the DMA arbiter
package dma_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_RESP} state_t;
  localparam logic MODE_LOAD  = 1'b0;
  localparam logic MODE_STORE = 1'b1;
  localparam logic SRC_ROM    = 1'b0;
  localparam logic SRC_RAM    = 1'b1;
endpackage

// File: rtl/dma_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first request at or after ptr wins
module rr_arbiter
  import dma_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;
  always_comb begin
    idx = '0;
    any = 1'b0;
    j = 0;
    // scan from farthest to nearest so the nearest set bit overwrites last
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        idx = IW'(j);
        any = 1'b1;
      end
    end
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/dma_arbiter.sv
// dma_arbiter: round-robin sharing of one DMA engine among requesters,
// one transfer in flight, latched command, response pulse and watchdog.
module dma_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_mode,
  input  logic [NUM_REQ-1:0]              req_src_sel,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rsp_err,
  output logic                            busy,
  output logic                            dma_start,
  output logic                            dma_mode,
  output logic                            dma_src_sel,
  output logic [ADDR_WIDTH-1:0]           dma_addr,
  output logic [DATA_WIDTH-1:0]           dma_data_in,
  input  logic                            dma_done,
  input  logic [DATA_WIDTH-1:0]           dma_data_out
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [IW-1:0] rr_ptr, grant, win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic win_any;
  logic [TW-1:0] timer;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(win_grant),
    .idx(win_idx),
    .any(win_any)
  );
  assign req_ready = (state == ST_IDLE && !rst) ? win_grant : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      timer       <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      dma_start   <= 1'b0;
      dma_mode    <= 1'b0;
      dma_src_sel <= 1'b0;
      dma_addr    <= '0;
      dma_data_in <= '0;
    end else begin
      case (state)
        ST_IDLE: if (win_any) begin
          dma_mode    <= req_mode[win_idx];
          dma_src_sel <= req_src_sel[win_idx];
          dma_addr    <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          dma_data_in <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
          grant       <= win_idx;
          rr_ptr      <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          dma_start   <= 1'b1;
          busy        <= 1'b1;
          state       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          dma_start <= 1'b0;
          timer     <= '0;
          state     <= ST_BUSY;
        end
        ST_BUSY: if (dma_done) begin
          rsp_data  <= (dma_mode == MODE_LOAD) ? dma_data_out : '0;
          rsp_err   <= 1'b0;
          rsp_valid <= NUM_REQ'(1) << grant;
          state     <= ST_RESP;
        end else if (timer == TW'(TIMEOUT)) begin
          rsp_data  <= '0;
          rsp_err   <= 1'b1;
          rsp_valid <= NUM_REQ'(1) << grant;
          state     <= ST_RESP;
        end else begin
          timer <= timer + 1'b1;
        end
        ST_RESP: begin
          rsp_valid <= '0;
          rsp_err   <= 1'b0;
          rsp_data  <= '0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed stimulus with a cycle-offset transaction model and per-cycle compare
module tb_dma_arbiter;
  localparam int N = 2, DW = 128, AW = 4, TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, req_mode = '0, req_src_sel = '0, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_data, dma_data_in, dma_data_out = '0, dma_rdata = '0;
  logic rsp_err, busy, dma_start, dma_mode, dma_src_sel, dma_done = 1'b0;
  logic [AW-1:0] dma_addr;
  bit dma_auto = 1'b0;
  int checks = 0, failures = 0, cyc = 0;

  dma_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_src_sel(req_src_sel), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .dma_start(dma_start), .dma_mode(dma_mode),
    .dma_src_sel(dma_src_sel), .dma_addr(dma_addr), .dma_data_in(dma_data_in),
    .dma_done(dma_done), .dma_data_out(dma_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction model: m_s counts cycles since the accept cycle; the command
  // goes out at offset 1, BUSY starts at offset 2, the response lands one cycle
  // after done is seen or after TIMEOUT+1 BUSY cycles without done.
  bit m_act = 0, m_mode = 0, m_src = 0, m_err = 0;
  int m_s = 0, m_rs = 0, m_ptr = 0, m_g = 0, m_w;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, m_rd = '0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  always_comb m_w = pick(req_valid, m_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 0;
      m_ptr <= 0;
    end else if (!m_act) begin
      if (m_w >= 0) begin
        m_act <= 1; m_s <= 1; m_rs <= 0; m_g <= m_w; m_ptr <= (m_w + 1) % N;
        m_mode <= req_mode[m_w]; m_src <= req_src_sel[m_w];
        m_addr <= req_addr[m_w*AW +: AW]; m_wd <= req_wdata[m_w*DW +: DW];
      end
    end else begin
      m_s <= m_s + 1;
      if (m_s == m_rs) m_act <= 0;
      else if (m_s >= 2 && m_rs == 0) begin
        if (dma_done) begin
          m_rs <= m_s + 1; m_err <= 0; m_rd <= m_mode ? '0 : dma_data_out;
        end else if (m_s - 2 == TO) begin
          m_rs <= m_s + 1; m_err <= 1; m_rd <= '0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("req_ready", req_ready, (!m_act && m_w >= 0) ? DW'(1) << m_w : '0);
      chk("dma_start", dma_start, m_act && m_s == 1);
      chk("busy", busy, m_act);
      chk("rsp_valid", rsp_valid, (m_act && m_s == m_rs) ? DW'(1) << m_g : '0);
      if (m_act && m_s == m_rs) begin
        chk("rsp_data", rsp_data, m_rd);
        chk("rsp_err", rsp_err, m_err);
      end
      if (m_act) begin
        chk("dma_mode", dma_mode, m_mode);
        chk("dma_src_sel", dma_src_sel, m_src);
        chk("dma_addr", dma_addr, m_addr);
        chk("dma_data_in", dma_data_in, m_wd);
      end
    end
  end

  // Event recorders read by the directed sequence one edge later.
  int acc_cnt = 0, acc_cyc = 0, st_cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
  int acc_q[$], acc_cq[$];
  logic st_mode, st_src, rsp_e;
  logic [AW-1:0] st_addr;
  logic [N-1:0] rsp_vec;
  logic [DW-1:0] rsp_d;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if ((req_ready & req_valid) != 0) begin
        acc_cnt++; acc_cyc = cyc; acc_q.push_back(req_ready[1] ? 1 : 0); acc_cq.push_back(cyc);
      end
      if (dma_start) begin
        st_cyc = cyc; st_mode = dma_mode; st_src = dma_src_sel; st_addr = dma_addr;
      end
      if (rsp_valid != 0) begin
        rsp_cnt++; rsp_cyc = cyc; rsp_vec = rsp_valid; rsp_d = rsp_data; rsp_e = rsp_err;
      end
    end
  end

  // Fixed-latency DMA: done rises three cycles after the start cycle, for one cycle.
  initial forever begin
    @(negedge clk);
    if (dma_auto && dma_start && !rst) begin
      repeat (3) @(posedge clk);
      #1 dma_done = 1; dma_data_out = dma_rdata;
      @(posedge clk);
      #1 dma_done = 0;
    end
  end

  task automatic issue_req(input int i, input bit mode, input bit src, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int base;
    req_mode[i] = mode; req_src_sel[i] = src;
    req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = wd;
    req_valid[i] = 1'b1;
    base = acc_cnt;
    for (int k = 0; k < 40 && acc_cnt == base; k++) @(posedge clk);
    chk("accept_seen", acc_cnt != base, 1);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int lim);
    int base = rsp_cnt;
    for (int k = 0; k < lim && rsp_cnt == base; k++) @(posedge clk);
    chk("rsp_seen", rsp_cnt != base, 1);
    #1;
  endtask

  initial begin
    int exp_g[4] = '{0, 1, 0, 1};
    int base;
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dma_start", dma_start, 0);
    chk("rst_dma_mode", dma_mode, 0);
    chk("rst_dma_src_sel", dma_src_sel, 0);
    chk("rst_dma_addr", dma_addr, 0);
    chk("rst_dma_data_in", dma_data_in, 0);
    @(posedge clk); #1 req_valid = 0; rst = 0;
    @(posedge clk); #1;

    // single load
    dma_rdata = 128'h0123456789ABCDEF0123456789ABCDEF; dma_auto = 1;
    issue_req(0, 0, 0, 4'd3, '0);
    wait_rsp(20);
    chk("load_start_lat", st_cyc - acc_cyc, 1);
    chk("load_start_addr", st_addr, 3);
    chk("load_rsp_lat", rsp_cyc - acc_cyc, 5);
    chk("load_rsp_vec", rsp_vec, 2'b01);
    chk("load_rsp_data", rsp_d, 128'h0123456789ABCDEF0123456789ABCDEF);
    chk("load_rsp_err", rsp_e, 0);

    // store
    dma_rdata = {8{16'h5555}};
    issue_req(1, 1, 1, 4'd7, {16{8'hAA}});
    wait_rsp(20);
    chk("store_mode", st_mode, 1);
    chk("store_src", st_src, 1);
    chk("store_addr", st_addr, 7);
    chk("store_rsp_vec", rsp_vec, 2'b10);
    chk("store_rsp_data", rsp_d, 0);

    // fairness with both requesters held
    acc_q.delete(); acc_cq.delete();
    req_mode = 0; req_src_sel = 0; req_valid = 2'b11;
    for (int t = 0; t < 4; t++) wait_rsp(30);
    req_valid = 0;
    chk("fair_count", acc_q.size(), 4);
    for (int t = 0; t < 4 && t < acc_q.size(); t++) chk($sformatf("fair_grant%0d", t), acc_q[t], exp_g[t]);
    for (int t = 0; t + 1 < acc_cq.size(); t++) chk($sformatf("fair_gap%0d", t), acc_cq[t+1] - acc_cq[t], 6);

    // watchdog timeout, then a normal transfer
    dma_auto = 0; dma_done = 0;
    issue_req(0, 0, 0, 4'd5, '0);
    wait_rsp(40);
    chk("to_err", rsp_e, 1);
    chk("to_data", rsp_d, 0);
    chk("to_vec", rsp_vec, 2'b01);
    chk("to_lat_from_busy", rsp_cyc - (acc_cyc + 2), 17);
    dma_rdata = 128'hDEADBEEF_00000000_11111111_CAFEF00D; dma_auto = 1;
    issue_req(1, 0, 1, 4'd2, '0);
    wait_rsp(20);
    chk("after_to_err", rsp_e, 0);
    chk("after_to_vec", rsp_vec, 2'b10);
    chk("after_to_data", rsp_d, 128'hDEADBEEF_00000000_11111111_CAFEF00D);

    // stray / sticky done in IDLE and ISSUE
    dma_auto = 0; dma_done = 1; dma_data_out = {4{32'hFEED1234}};
    repeat (3) @(posedge clk); #1;
    issue_req(0, 0, 0, 4'd9, '0);
    @(posedge clk); #1 dma_done = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 dma_done = 1;
    wait_rsp(10);
    dma_done = 0;
    chk("stray_rsp_lat", rsp_cyc - acc_cyc, 5);
    chk("stray_rsp_data", rsp_d, {4{32'hFEED1234}});
    chk("stray_rsp_err", rsp_e, 0);

    // reset while BUSY
    base = rsp_cnt;
    issue_req(0, 1, 1, 4'hC, {16{8'h3C}});
    repeat (3) @(posedge clk);
    #1 rst = 1; req_valid = 2'b11;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_dma_addr", dma_addr, 0);
    chk("mid_rst_dma_mode", dma_mode, 0);
    chk("mid_rst_dma_src", dma_src_sel, 0);
    chk("mid_rst_dma_data_in", dma_data_in, 0);
    chk("mid_rst_no_rsp", rsp_cnt, base);
    @(posedge clk); #1 rst = 0; dma_auto = 1; req_mode = 0;
    base = acc_cnt;
    for (int k = 0; k < 10 && acc_cnt == base; k++) @(posedge clk);
    chk("post_rst_accept", acc_cnt != base, 1);
    chk("post_rst_grant", acc_q[$], 0);
    wait_rsp(20);
    req_valid = 0;
    chk("post_rst_rsp_vec", rsp_vec, 2'b01);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
